// File: rtl/rr_mux_arbiter_if.sv
// Bundle for the round-robin 4:1 arbiter: requester side and consumer side.
// Build option: ARB_LOCK_EN adds the per-requester lock inputs.
//
// Handshake rules: requester i offers d<i> while req[i]=1 and must hold both
// stable until it sees gnt[i]=1 (gnt is combinational, and the word is taken
// at that rising edge). The consumer takes out_data on every rising edge where
// out_valid=1 and out_ready=1. out_ready has no effect while out_valid=0.
interface rr_mux_arbiter_if #(parameter int DATA_W = 4);
  logic [3:0]        req;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic [3:0]        gnt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        sel;
`ifdef ARB_LOCK_EN
  logic [3:0]        lock;
`endif

  // Arbiter side.
  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt, out_valid, out_data, sel
  );

  // Requesters plus consumer side.
  modport master (
    output req, d0, d1, d2, d3, out_ready,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt, out_valid, out_data, sel
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbitrated 4:1 word multiplexer with a one-entry output register.
// Build option: ARB_LOCK_EN enables the OPEN/LOCKED ownership state machine.
// dbg_state reports the lock state: 0 = OPEN, 1 = LOCKED.
module rr_mux_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_mux_arbiter_if.slave     bus,
  output logic                dbg_state
);

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        sel_q, sel_d;
`ifdef ARB_LOCK_EN
  logic [1:0]        owner_q, owner_d;
`endif

  logic [3:0] elig;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;
  logic       space;
  logic       capture;

  // Pick the first eligible requester, searching from the one after ptr.
  always_comb begin
    elig = bus.req;
`ifdef ARB_LOCK_EN
    if (state_q == ST_LOCKED) elig = bus.req & (4'b0001 << owner_q);
`endif
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    space   = !out_valid_q || bus.out_ready;
    capture = space && found;
  end

  // Output register, pointer and lock-state next values.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    state_d     = state_q;
    if (capture) begin
      case (win)
        2'd0:    out_data_d = bus.d0;
        2'd1:    out_data_d = bus.d1;
        2'd2:    out_data_d = bus.d2;
        default: out_data_d = bus.d3;
      endcase
      sel_d       = win;
      out_valid_d = 1'b1;
      ptr_d       = win;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ARB_LOCK_EN
    owner_d = owner_q;
    case (state_q)
      ST_OPEN: begin
        if (capture && bus.lock[win]) begin
          state_d = ST_LOCKED;
          owner_d = win;
        end
      end
      default: begin
        // Owner releases either with its final word or by withdrawing.
        if (!bus.lock[owner_q] && (capture || !bus.req[owner_q])) begin
          state_d = ST_OPEN;
          ptr_d   = owner_q;
        end
      end
    endcase
`else
    state_d = ST_OPEN;
`endif
  end

  // State register; reset clears any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OPEN;
      ptr_q       <= 2'd3;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 2'd0;
`ifdef ARB_LOCK_EN
      owner_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
`ifdef ARB_LOCK_EN
      owner_q     <= owner_d;
`endif
    end
  end

  // Grant is a same-cycle accept, suppressed while reset is asserted.
  always_comb begin
    bus.gnt = (capture && rst_n) ? (4'b0001 << win) : 4'b0000;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sel       = sel_q;
  assign dbg_state     = (state_q == ST_LOCKED);

endmodule
